// File: rtl/chn_loop_accum.sv
// Channel-loop accumulator: sums LANES signed lanes over a programmable number of beats.
// Optional saturating arithmetic and sat_flag output when CHN_LOOP_ACCUM_SAT_EN is defined.
module chn_loop_accum #(
  parameter int unsigned LANES    = 64,
  parameter int unsigned DW       = 16,
  parameter int unsigned ACC_W    = 20,
  parameter int unsigned MAX_LOOP = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_v,
  input  logic [LANES*DW-1:0]      in_data,
  input  logic                     halt,
  input  logic                     flush,
  input  logic [CNT_W-1:0]         cfg_len,
  output logic                     out_v,
  output logic [LANES*ACC_W-1:0]   out_data,
  output logic                     busy,
  output logic [CNT_W-1:0]         loop_idx
`ifdef CHN_LOOP_ACCUM_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam logic [CNT_W-1:0] MaxLen = CNT_W'(MAX_LOOP);
  localparam logic [CNT_W-1:0] OneLen = CNT_W'(1);

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       len_q, len_d;
  logic [LANES*ACC_W-1:0] acc_q, acc_d;
  logic                   out_v_q, out_v_d;
  logic [LANES*ACC_W-1:0] out_data_q, out_data_d;

  logic [CNT_W-1:0]       cfg_clamped;
  logic [CNT_W-1:0]       eff_len;
  logic                   first_beat;
  logic                   last_beat;
  logic [LANES*ACC_W-1:0] next_sum;

  logic signed [DW-1:0]    lane_in;
  logic signed [ACC_W-1:0] lane_base;
  logic signed [ACC_W-1:0] lane_sum;

`ifdef CHN_LOOP_ACCUM_SAT_EN
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] lane_wide;
  logic                  any_sat;
  logic                  sticky_q, sticky_d;
  logic                  sat_flag_q, sat_flag_d;
  logic                  sticky_next;
`endif

  // Length is only taken from cfg_len on the first beat of a group.
  always_comb begin
    cfg_clamped = cfg_len;
    if (cfg_len == '0) begin
      cfg_clamped = OneLen;
    end else if (cfg_len > MaxLen) begin
      cfg_clamped = MaxLen;
    end
  end

  assign first_beat = (cnt_q == '0);
  assign eff_len    = first_beat ? cfg_clamped : len_q;
  assign last_beat  = (cnt_q == (eff_len - OneLen));

  always_comb begin
    next_sum  = '0;
    lane_in   = '0;
    lane_base = '0;
    lane_sum  = '0;
`ifdef CHN_LOOP_ACCUM_SAT_EN
    lane_wide = '0;
    any_sat   = 1'b0;
`endif
    for (int i = 0; i < LANES; i++) begin
      lane_in   = $signed(in_data[i*DW +: DW]);
      lane_base = first_beat ? '0 : $signed(acc_q[i*ACC_W +: ACC_W]);
`ifdef CHN_LOOP_ACCUM_SAT_EN
      lane_wide = (ACC_W+1)'(lane_base) + (ACC_W+1)'(lane_in);
      // Overflow iff the two top bits of the widened sum disagree.
      if (lane_wide[ACC_W] != lane_wide[ACC_W-1]) begin
        lane_sum = lane_wide[ACC_W] ? AccMin : AccMax;
        any_sat  = 1'b1;
      end else begin
        lane_sum = lane_wide[ACC_W-1:0];
      end
`else
      lane_sum = lane_base + ACC_W'(lane_in);
`endif
      next_sum[i*ACC_W +: ACC_W] = lane_sum;
    end
  end

`ifdef CHN_LOOP_ACCUM_SAT_EN
  assign sticky_next = (first_beat ? 1'b0 : sticky_q) | any_sat;
`endif

  always_comb begin
    cnt_d      = cnt_q;
    len_d      = len_q;
    acc_d      = acc_q;
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
`ifdef CHN_LOOP_ACCUM_SAT_EN
    sticky_d   = sticky_q;
    sat_flag_d = sat_flag_q;
`endif
    if (!halt) begin
      out_v_d = 1'b0;
      if (flush) begin
        cnt_d = '0;
        acc_d = '0;
`ifdef CHN_LOOP_ACCUM_SAT_EN
        sticky_d = 1'b0;
`endif
      end else if (in_v) begin
        if (first_beat) begin
          len_d = cfg_clamped;
        end
        if (last_beat) begin
          out_data_d = next_sum;
          out_v_d    = 1'b1;
          cnt_d      = '0;
`ifdef CHN_LOOP_ACCUM_SAT_EN
          sticky_d   = 1'b0;
          sat_flag_d = sticky_next;
`endif
        end else begin
          acc_d = next_sum;
          cnt_d = cnt_q + OneLen;
`ifdef CHN_LOOP_ACCUM_SAT_EN
          sticky_d = sticky_next;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      len_q      <= OneLen;
      acc_q      <= '0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
`ifdef CHN_LOOP_ACCUM_SAT_EN
      sticky_q   <= 1'b0;
      sat_flag_q <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
`ifdef CHN_LOOP_ACCUM_SAT_EN
      sticky_q   <= sticky_d;
      sat_flag_q <= sat_flag_d;
`endif
    end
  end

  assign out_v    = out_v_q;
  assign out_data = out_data_q;
  assign loop_idx = cnt_q;
  assign busy     = (cnt_q != '0);
`ifdef CHN_LOOP_ACCUM_SAT_EN
  assign sat_flag = sat_flag_q;
`endif

endmodule

// File: tb/tb_chn_loop_accum.sv
// Bench for chn_loop_accum: directed vector table, randomized run against a reference model,
// and a narrow-accumulator instance for wrap/saturation corners.
module tb_chn_loop_accum;

  localparam int L    = 64;
  localparam int DW   = 16;
  localparam int AW   = 20;
  localparam int MAXL = 16;
  localparam int CW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_v, halt, flush;
  logic [CW-1:0]     cfg_len;
  logic [L*DW-1:0]   in_data;
  logic              out_v, busy;
  logic [L*AW-1:0]   out_data;
  logic [CW-1:0]     loop_idx;

  logic              s_rst, s_in_v, s_halt, s_flush;
  logic [CW-1:0]     s_cfg;
  logic [2*DW-1:0]   s_data;
  logic              s_out_v, s_busy;
  logic [2*DW-1:0]   s_out;
  logic [CW-1:0]     s_idx;
`ifdef CHN_LOOP_ACCUM_SAT_EN
  logic              sat_flag, s_sat_flag;
`endif

  chn_loop_accum #(
    .LANES(L), .DW(DW), .ACC_W(AW), .MAX_LOOP(MAXL), .CNT_W(CW)
  ) u_dut (
    .clk(clk), .rst(rst), .in_v(in_v), .in_data(in_data), .halt(halt), .flush(flush),
    .cfg_len(cfg_len), .out_v(out_v), .out_data(out_data), .busy(busy), .loop_idx(loop_idx)
`ifdef CHN_LOOP_ACCUM_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  chn_loop_accum #(
    .LANES(2), .DW(16), .ACC_W(16), .MAX_LOOP(MAXL), .CNT_W(CW)
  ) u_narrow (
    .clk(clk), .rst(s_rst), .in_v(s_in_v), .in_data(s_data), .halt(s_halt), .flush(s_flush),
    .cfg_len(s_cfg), .out_v(s_out_v), .out_data(s_out), .busy(s_busy), .loop_idx(s_idx)
`ifdef CHN_LOOP_ACCUM_SAT_EN
    , .sat_flag(s_sat_flag)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit rst; bit in_v; bit halt; bit flush; int cfg; int val; int mul;
    bit e_ov; int e_idx; bit e_busy; int e_l0; int e_ln;
  } vec_t;

  vec_t tbl[$];
  int   r_lane[L];

  // Reference model state
  bit     model_on = 1'b0;
  int     m_cnt, m_len;
  bit     m_ov, m_sticky, m_flag;
  longint m_acc[L];
  longint m_out[L];

  function automatic vec_t mk(bit r, bit iv, bit h, bit f, int c, int v, int m,
                              bit ov, int idx, bit b, int l0, int ln);
    vec_t t;
    t.rst = r; t.in_v = iv; t.halt = h; t.flush = f; t.cfg = c; t.val = v; t.mul = m;
    t.e_ov = ov; t.e_idx = idx; t.e_busy = b; t.e_l0 = l0; t.e_ln = ln;
    return t;
  endfunction

  function automatic longint wrapv(longint v, int w);
    longint m;
    m = v & ((64'sd1 <<< w) - 1);
    if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
    return m;
  endfunction

  function automatic int lane_out(int i);
    logic signed [AW-1:0] t;
    t = out_data[i*AW +: AW];
    return int'(t);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pack_lanes();
    for (int i = 0; i < L; i++) in_data[i*DW +: DW] = DW'(r_lane[i]);
  endtask

  task automatic model_step();
    longint s[L];
    longint mx, mn;
    bit any;
    mx = (64'sd1 <<< (AW - 1)) - 1;
    mn = -(64'sd1 <<< (AW - 1));
    if (!rst) begin
      m_cnt = 0; m_len = 1; m_ov = 0; m_sticky = 0; m_flag = 0;
      for (int i = 0; i < L; i++) begin m_acc[i] = 0; m_out[i] = 0; end
    end else if (!halt) begin
      m_ov = 0;
      if (flush) begin
        m_cnt = 0; m_sticky = 0;
        for (int i = 0; i < L; i++) m_acc[i] = 0;
      end else if (in_v) begin
        if (m_cnt == 0) begin
          m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAXL) ? MAXL : int'(cfg_len));
          m_sticky = 0;
        end
        any = 0;
        for (int i = 0; i < L; i++) begin
          s[i] = ((m_cnt == 0) ? 0 : m_acc[i]) + longint'(r_lane[i]);
`ifdef CHN_LOOP_ACCUM_SAT_EN
          if (s[i] > mx) begin s[i] = mx; any = 1; end
          else if (s[i] < mn) begin s[i] = mn; any = 1; end
`else
          s[i] = wrapv(s[i], AW);
`endif
        end
        m_sticky = m_sticky | any;
        if (m_cnt == m_len - 1) begin
          for (int i = 0; i < L; i++) m_out[i] = s[i];
          m_ov = 1; m_cnt = 0; m_flag = m_sticky;
        end else begin
          for (int i = 0; i < L; i++) m_acc[i] = s[i];
          m_cnt++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    #1;
  endtask

  initial begin
    int bad;
    rst = 0; in_v = 0; halt = 0; flush = 0; cfg_len = '0; in_data = '0;
    s_rst = 0; s_in_v = 0; s_halt = 0; s_flush = 0; s_cfg = '0; s_data = '0;

    //        rst iv h f cfg val    mul  ov idx b  l0      ln
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 3, 0, 1,      0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 3, 0, 1,      0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 3, 0, 1,      1, 0, 0, 0, 189));
    tbl.push_back(mk(1, 0, 0, 0, 3, 0, 0,      0, 0, 0, 0, 189));
    tbl.push_back(mk(1, 1, 0, 0, 1, 5, 0,      1, 0, 0, 5, 5));
    tbl.push_back(mk(1, 1, 0, 0, 1, -7, 0,     1, 0, 0, -7, -7));
    tbl.push_back(mk(1, 1, 0, 0, 1, 100, 0,    1, 0, 0, 100, 100));
    tbl.push_back(mk(1, 1, 0, 0, 1, -32768, 0, 1, 0, 0, -32768, -32768));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0,      0, 0, 0, -32768, -32768));
    tbl.push_back(mk(1, 1, 0, 0, 4, 10, 0,     0, 1, 1, -32768, -32768));
    tbl.push_back(mk(1, 1, 0, 0, 4, 10, 0,     0, 2, 1, -32768, -32768));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 1, 1, 0, 4, 10, 0,   0, 2, 1, -32768, -32768));
    tbl.push_back(mk(1, 1, 0, 0, 4, 10, 0,     0, 3, 1, -32768, -32768));
    tbl.push_back(mk(1, 1, 0, 0, 4, 10, 0,     1, 0, 0, 40, 40));
    tbl.push_back(mk(1, 1, 1, 0, 4, 10, 0,     1, 0, 0, 40, 40));
    tbl.push_back(mk(1, 1, 1, 0, 4, 10, 0,     1, 0, 0, 40, 40));
    tbl.push_back(mk(1, 0, 0, 0, 4, 0, 0,      0, 0, 0, 40, 40));
    tbl.push_back(mk(1, 1, 0, 0, 3, 7, 0,      0, 1, 1, 40, 40));
    tbl.push_back(mk(1, 1, 0, 0, 3, 7, 0,      0, 2, 1, 40, 40));
    tbl.push_back(mk(1, 1, 0, 1, 3, 7, 0,      0, 0, 0, 40, 40));
    tbl.push_back(mk(1, 1, 0, 0, 3, 1, 0,      0, 1, 1, 40, 40));
    tbl.push_back(mk(1, 1, 0, 0, 3, 1, 0,      0, 2, 1, 40, 40));
    tbl.push_back(mk(1, 1, 0, 0, 3, 1, 0,      1, 0, 0, 3, 3));
    tbl.push_back(mk(1, 1, 0, 0, 2, 2, 0,      0, 1, 1, 3, 3));
    tbl.push_back(mk(1, 1, 0, 0, 5, 3, 0,      1, 0, 0, 5, 5));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(1, 1, 0, 0, 5, 4, 0,    0, k, 1, 5, 5));
    tbl.push_back(mk(1, 1, 0, 0, 5, 4, 0,      1, 0, 0, 20, 20));
    tbl.push_back(mk(1, 1, 0, 0, 0, 9, 0,      1, 0, 0, 9, 9));
    tbl.push_back(mk(1, 1, 0, 0, 0, -1, 0,     1, 0, 0, -1, -1));
    tbl.push_back(mk(1, 1, 0, 0, 3, 1, 0,      0, 1, 1, -1, -1));
    tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 6, 0,      0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2, 6, 0,      1, 0, 0, 12, 12));

    for (int v = 0; v < tbl.size(); v++) begin
      rst = tbl[v].rst; in_v = tbl[v].in_v; halt = tbl[v].halt; flush = tbl[v].flush;
      cfg_len = CW'(tbl[v].cfg);
      for (int i = 0; i < L; i++) r_lane[i] = tbl[v].val + tbl[v].mul * i;
      pack_lanes();
      tick();
      chk($sformatf("vec%0d out_v", v), out_v, tbl[v].e_ov);
      chk($sformatf("vec%0d loop_idx", v), loop_idx, tbl[v].e_idx);
      chk($sformatf("vec%0d busy", v), busy, tbl[v].e_busy);
      chk($sformatf("vec%0d lane0", v), lane_out(0), tbl[v].e_l0);
      chk($sformatf("vec%0d lane%0d", v, L - 1), lane_out(L - 1), tbl[v].e_ln);
    end

    // Randomized run against the reference model, starting from a reset.
    model_on = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      rst     = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      halt    = ($urandom_range(0, 7) == 0);
      flush   = ($urandom_range(0, 11) == 0);
      in_v    = ($urandom_range(0, 3) != 0);
      cfg_len = CW'($urandom_range(0, 20));
      for (int i = 0; i < L; i++) begin
        case ($urandom_range(0, 3))
          0:       r_lane[i] = 32767;
          1:       r_lane[i] = -32768;
          default: r_lane[i] = int'($urandom_range(0, 65535)) - 32768;
        endcase
      end
      pack_lanes();
      tick();
      chk("rand out_v", out_v, m_ov);
      chk("rand loop_idx", loop_idx, m_cnt);
      chk("rand busy", busy, (m_cnt != 0));
      bad = -1;
      for (int i = 0; i < L; i++)
        if (bad < 0 && longint'(lane_out(i)) != m_out[i]) bad = i;
      chk($sformatf("rand out_data lane%0d", (bad < 0) ? 0 : bad),
          lane_out((bad < 0) ? 0 : bad), m_out[(bad < 0) ? 0 : bad]);
`ifdef CHN_LOOP_ACCUM_SAT_EN
      chk("rand sat_flag", sat_flag, m_flag);
`endif
    end
    model_on = 1'b0;

    // Narrow instance: ACC_W == DW, overflow on both polarities.
    s_rst = 0; tick();
    s_rst = 1; s_in_v = 1; s_cfg = CW'(2);
    s_data = {16'h8000, 16'h7fff}; tick();
    chk("narrow first beat out_v", s_out_v, 0);
    s_data = {16'hffff, 16'h0001}; tick();
    chk("narrow ovf out_v", s_out_v, 1);
`ifdef CHN_LOOP_ACCUM_SAT_EN
    chk("narrow sat lane0", $signed(s_out[15:0]), 32767);
    chk("narrow sat lane1", $signed(s_out[31:16]), -32768);
    chk("narrow sat_flag set", s_sat_flag, 1);
`else
    chk("narrow wrap lane0", $signed(s_out[15:0]), -32768);
    chk("narrow wrap lane1", $signed(s_out[31:16]), 32767);
`endif
    s_data = {16'h0001, 16'h0001}; tick();
    tick();
    chk("narrow clean out_v", s_out_v, 1);
    chk("narrow clean lane0", $signed(s_out[15:0]), 2);
`ifdef CHN_LOOP_ACCUM_SAT_EN
    chk("narrow sat_flag clear", s_sat_flag, 0);
`endif
    s_in_v = 0; tick();
    chk("narrow idle out_v", s_out_v, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
